sentinel_auth_ctrl: RTL and testbench
=====================================

Name: sentinel_auth_ctrl

Overview:
Sequencing controller for the Sentinel lock. It accepts a multi-byte key entered one byte per strobe and compares the whole sequence in constant time, with no early abort. It counts failed attempts, enforces a lockout window, and holds a timed grant. It also latches tamper events from the output-integrity monitor. It sits between the DIP-switch input and the display/status drivers, and supplies the registered `grant` that gates the "U" display and the glow array.

Parameters:
- KEY_LEN, 3: number of key bytes per attempt (1..8).
- KEY_SEQ, 24'hC3_5A_B6: expected sequence, 8*KEY_LEN bits. Byte 0 is bits [7:0] and is entered first.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout (1..15).
- ENTRY_TIMEOUT, 256: max cycles allowed between strobes inside an attempt.
- LOCKOUT_CYCLES, 65536: lockout duration in cycles.
- HOLD_CYCLES, 4096: grant duration in cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- ena  in  1  tile enable
- key_byte  in  8  key byte, sampled only when key_strobe=1
- key_strobe  in  1  single-cycle pulse, one byte per pulse
- tamper_in  in  1  drive-fight tamper flag from loopback monitor, level-sensitive
- relock_req  in  1  synchronous request to drop grant
- grant  out  1  authorization granted
- lockout  out  1  lockout window active
- tampered  out  1  sticky tamper latch
- fail_count  out  4  consecutive failed attempts
- state_o  out  3  current state encoding, for telemetry

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- All outputs are registered.
- Reset values:
  - state = LOCKED
  - grant = 0, lockout = 0, tampered = 0
  - fail_count = 0
  - byte index = 0, mismatch flag = 0, timer = 0
- Priority at each edge: tamper_in > ena=0 > relock_req > strobe/timer events.
- States:
  - LOCKED (0):
    - Strobe: compare key_byte against byte 0 and set mismatch flag = (key_byte != byte 0).
    - Then idx = 1, load timer = ENTRY_TIMEOUT, go ENTRY.
    - If KEY_LEN = 1, evaluate the attempt immediately instead of entering ENTRY.
  - ENTRY (1):
    - Strobe: mismatch |= (key_byte != KEY_SEQ[idx]); idx++; reload timer.
    - On the KEY_LEN-th byte, evaluate the attempt.
    - Timer reaches 0 with no strobe: abort and count as a failed attempt.
  - Attempt evaluation:
    - Pass: go GRANTED; fail_count = 0; timer = HOLD_CYCLES.
    - Fail: fail_count++. If the new value equals MAX_FAILS, go LOCKOUT with timer = LOCKOUT_CYCLES; otherwise go LOCKED.
    - In both cases idx and mismatch flag clear.
  - GRANTED (2):
    - grant = 1.
    - Timer expiry or relock_req: go LOCKED, grant = 0.
    - Strobes are ignored.
  - LOCKOUT (3):
    - lockout = 1; strobes are ignored.
    - Timer reaches 0: go LOCKED, fail_count = 0.
  - TAMPERED (4):
    - Entered the cycle after tamper_in=1, from any state.
    - Outputs: tampered = 1, grant = 0, lockout = 0.
    - Sticky: only rst_n exits this state.
- Latency: strobe of the final correct byte at edge N gives grant=1 after edge N. tamper_in at edge N clears grant at edge N.
- ena=0 by state:
  - ENTRY or GRANTED: go LOCKED, attempt discarded and not counted.
  - LOCKOUT: stay in LOCKOUT with the timer frozen, so toggling ena cannot escape lockout.
  - All states: strobes are ignored.
- fail_count saturates at MAX_FAILS and never wraps.
- Timer semantics: the timer decrements once per cycle while enabled. Expiry is the cycle it reads 0, so a load of T expires T+1 cycles later.
- A strobe in the same cycle as ENTRY timeout expiry: the strobe wins and the timer reloads.
- relock_req outside GRANTED: no effect.

Decomposition:
- sentinel_pkg holds:
  - state enum and its 3-bit encoding
  - default KEY_SEQ
  - timer width function: $clog2 of the max of the three cycle parameters, plus 1
- Sub-module sentinel_down_timer is the natural split: one loadable down-counter (load, load_val, en, expired) shared by ENTRY, GRANTED and LOCKOUT.

Test Plan:
Bench parameters: LOCKOUT_CYCLES=16, HOLD_CYCLES=32, ENTRY_TIMEOUT=8.
1. Reset, then strobe B6, 5A, C3 -> grant=1 the cycle after the 3rd strobe; fail_count=0; state_o=2; grant drops after 33 cycles.
2. Strobe B6, 00, C3 -> grant stays 0; fail_count=1; state LOCKED. There is no change after the 2nd strobe (no early abort).
3. Three bad attempts -> lockout=1, fail_count=3. Strobing during lockout does nothing; after 17 cycles lockout=0 and fail_count=0.
4. Strobe B6, then idle 9 cycles -> fail_count=1, state LOCKED. A later full correct sequence grants.
5. In GRANTED, assert tamper_in for 1 cycle -> grant=0 next edge; tampered=1, state_o=4. A correct sequence is ignored until rst_n pulses.
6. Cases:
   - ena=0 during ENTRY -> LOCKED, fail_count unchanged.
   - ena=0 for 10 cycles in LOCKOUT -> lockout lasts 10 extra cycles.
   - rst_n low mid-ENTRY -> all outputs return to reset values.

Source files
------------

// File: rtl/sentinel_pkg.sv
// Shared types and constants for the Sentinel lock authorization controller.
package sentinel_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_GRANTED  = 3'd2,
    ST_LOCKOUT  = 3'd3,
    ST_TAMPERED = 3'd4
  } state_e;

  // Factory key: byte 0 (0xB6) is entered first.
  localparam logic [23:0] DEFAULT_KEY_SEQ = 24'hC3_5A_B6;

  // Width of the shared down-timer: enough bits for the largest load value.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sentinel_down_timer.sv
// Loadable down-counter; holds at zero and reports expiry while it reads zero.
module sentinel_down_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_d, cnt_q;

  // Load wins over counting; counting stops at zero and freezes when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sentinel_auth_ctrl.sv
// Sentinel lock sequencing controller: constant-time multi-byte key compare,
// failed-attempt counting with lockout, timed grant and sticky tamper latch.
module sentinel_auth_ctrl
  import sentinel_pkg::*;
#(
  parameter int                   KEY_LEN        = 3,
  parameter logic [8*KEY_LEN-1:0] KEY_SEQ        = (8*KEY_LEN)'(DEFAULT_KEY_SEQ),
  parameter int                   MAX_FAILS      = 3,
  parameter int                   ENTRY_TIMEOUT  = 256,
  parameter int                   LOCKOUT_CYCLES = 65536,
  parameter int                   HOLD_CYCLES    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] key_byte,
  input  logic       key_strobe,
  input  logic       tamper_in,
  input  logic       relock_req,
  output logic       grant,
  output logic       lockout,
  output logic       tampered,
  output logic [3:0] fail_count,
  output logic [2:0] state_o
);

  localparam int TMR_W = timer_w(ENTRY_TIMEOUT, LOCKOUT_CYCLES, HOLD_CYCLES);
  localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  localparam logic [TMR_W-1:0] LD_ENTRY   = TMR_W'(ENTRY_TIMEOUT);
  localparam logic [TMR_W-1:0] LD_HOLD    = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] LD_LOCKOUT = TMR_W'(LOCKOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(KEY_LEN - 1);
  localparam logic [3:0]       FAIL_MAX   = 4'(MAX_FAILS);

  state_e           state_d, state_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             mis_d, mis_q;
  logic [3:0]       fail_d, fail_q;
  logic             grant_d, grant_q;
  logic             lockout_d, lockout_q;
  logic             tampered_d, tampered_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;

  // Expected key byte at a given position; a mux over all positions so the
  // compare takes the same path whatever the index.
  function automatic logic [7:0] key_at(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (idx == IDX_W'(i)) b = KEY_SEQ[8*i +: 8];
    end
    return b;
  endfunction

  sentinel_down_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (ena),
    .expired  (tmr_expired)
  );

  // Next-state, attempt evaluation and registered-output precompute.
  always_comb begin
    logic eval;
    logic eval_mis;
    logic m;
    logic [3:0] fail_inc;

    state_d  = state_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    eval     = 1'b0;
    eval_mis = 1'b0;
    m        = 1'b0;
    fail_inc = (fail_q < FAIL_MAX) ? (fail_q + 1'b1) : fail_q;

    if (tamper_in || (state_q == ST_TAMPERED)) begin
      state_d = ST_TAMPERED;
    end else if (!ena) begin
      // Abandoned attempts and grants fall back to LOCKED uncounted; lockout
      // holds with its timer frozen.
      if ((state_q == ST_ENTRY) || (state_q == ST_GRANTED)) begin
        state_d = ST_LOCKED;
        idx_d   = '0;
        mis_d   = 1'b0;
      end
    end else begin
      case (state_q)
        ST_LOCKED: begin
          if (key_strobe) begin
            m = (key_byte != key_at('0));
            if (KEY_LEN == 1) begin
              eval     = 1'b1;
              eval_mis = m;
            end else begin
              mis_d    = m;
              idx_d    = IDX_W'(1);
              tmr_load = 1'b1;
              tmr_val  = LD_ENTRY;
              state_d  = ST_ENTRY;
            end
          end
        end
        ST_ENTRY: begin
          if (key_strobe) begin
            m = mis_q | (key_byte != key_at(idx_q));
            if (idx_q == IDX_LAST) begin
              eval     = 1'b1;
              eval_mis = m;
            end else begin
              mis_d    = m;
              idx_d    = idx_q + 1'b1;
              tmr_load = 1'b1;
              tmr_val  = LD_ENTRY;
            end
          end else if (tmr_expired) begin
            eval     = 1'b1;
            eval_mis = 1'b1;
          end
        end
        ST_GRANTED: begin
          if (relock_req || tmr_expired) state_d = ST_LOCKED;
        end
        ST_LOCKOUT: begin
          if (tmr_expired) begin
            state_d = ST_LOCKED;
            fail_d  = '0;
          end
        end
        default: state_d = ST_LOCKED;
      endcase

      if (eval) begin
        idx_d = '0;
        mis_d = 1'b0;
        if (!eval_mis) begin
          state_d  = ST_GRANTED;
          fail_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = LD_LOCKOUT;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
    end

    grant_d    = (state_d == ST_GRANTED);
    lockout_d  = (state_d == ST_LOCKOUT);
    tampered_d = (state_d == ST_TAMPERED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOCKED;
      idx_q      <= '0;
      mis_q      <= 1'b0;
      fail_q     <= '0;
      grant_q    <= 1'b0;
      lockout_q  <= 1'b0;
      tampered_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mis_q      <= mis_d;
      fail_q     <= fail_d;
      grant_q    <= grant_d;
      lockout_q  <= lockout_d;
      tampered_q <= tampered_d;
    end
  end

  assign grant      = grant_q;
  assign lockout    = lockout_q;
  assign tampered   = tampered_q;
  assign fail_count = fail_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sentinel_auth_ctrl.sv
// Directed self-checking bench for sentinel_auth_ctrl with short timer values.
module tb_sentinel_auth_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] key_byte;
  logic       key_strobe;
  logic       tamper_in;
  logic       relock_req;
  logic       grant;
  logic       lockout;
  logic       tampered;
  logic [3:0] fail_count;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  sentinel_auth_ctrl #(
    .ENTRY_TIMEOUT  (8),
    .LOCKOUT_CYCLES (16),
    .HOLD_CYCLES    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .key_byte   (key_byte),
    .key_strobe (key_strobe),
    .tamper_in  (tamper_in),
    .relock_req (relock_req),
    .grant      (grant),
    .lockout    (lockout),
    .tampered   (tampered),
    .fail_count (fail_count),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n active edges; return 1ns after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    key_byte   = b;
    key_strobe = 1'b1;
    tick(1);
    key_strobe = 1'b0;
  endtask

  task automatic attempt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    strobe(b0);
    strobe(b1);
    strobe(b2);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; key_byte = 8'h00; key_strobe = 1'b0;
    tamper_in = 1'b0; relock_req = 1'b0;
    tick(2);
    chk("rst_grant", grant, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_tampered", tampered, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_state", state_o, 0);
    rst_n = 1'b1;
    tick(1);

    // 1: correct sequence grants, hold lasts 33 cycles
    strobe(8'hB6);
    chk("t1_entry_state", state_o, 1);
    strobe(8'h5A);
    chk("t1_no_grant_yet", grant, 0);
    strobe(8'hC3);
    chk("t1_grant", grant, 1);
    chk("t1_state", state_o, 2);
    chk("t1_fail", fail_count, 0);
    tick(32);
    chk("t1_grant_hold32", grant, 1);
    tick(1);
    chk("t1_grant_drop33", grant, 0);
    chk("t1_state_locked", state_o, 0);

    // 2: wrong middle byte, no early abort
    strobe(8'hB6);
    strobe(8'h00);
    chk("t2_still_entry", state_o, 1);
    chk("t2_fail_unchanged", fail_count, 0);
    strobe(8'hC3);
    chk("t2_grant", grant, 0);
    chk("t2_fail", fail_count, 1);
    chk("t2_state", state_o, 0);

    // 3: reach lockout, strobes ignored, exit after 17 cycles
    attempt(8'h00, 8'h00, 8'h00);
    chk("t3_fail2", fail_count, 2);
    attempt(8'h11, 8'h22, 8'h33);
    chk("t3_lockout", lockout, 1);
    chk("t3_fail3", fail_count, 3);
    chk("t3_state", state_o, 3);
    strobe(8'hB6);
    chk("t3_strobe_ignored", state_o, 3);
    tick(15);
    chk("t3_lockout_16", lockout, 1);
    tick(1);
    chk("t3_lockout_end", lockout, 0);
    chk("t3_fail_clear", fail_count, 0);
    chk("t3_state_end", state_o, 0);

    // 4: entry timeout counts as failure; strobe on expiry cycle wins
    strobe(8'hB6);
    tick(8);
    chk("t4_entry_8", state_o, 1);
    tick(1);
    chk("t4_timeout_state", state_o, 0);
    chk("t4_timeout_fail", fail_count, 1);
    strobe(8'hB6);
    tick(8);
    strobe(8'h5A);
    chk("t4_strobe_wins", state_o, 1);
    chk("t4_strobe_wins_fail", fail_count, 1);
    strobe(8'hC3);
    chk("t4_grant", grant, 1);
    chk("t4_fail_clear", fail_count, 0);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("t4_relock_grant", grant, 0);
    chk("t4_relock_state", state_o, 0);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("t4_relock_noop", state_o, 0);

    // 5: tamper in GRANTED is sticky until reset
    attempt(8'hB6, 8'h5A, 8'hC3);
    chk("t5_grant", grant, 1);
    tamper_in = 1'b1;
    tick(1);
    tamper_in = 1'b0;
    chk("t5_grant_off", grant, 0);
    chk("t5_tampered", tampered, 1);
    chk("t5_state", state_o, 4);
    chk("t5_lockout", lockout, 0);
    attempt(8'hB6, 8'h5A, 8'hC3);
    chk("t5_ignored_grant", grant, 0);
    chk("t5_ignored_state", state_o, 4);
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst_tampered", tampered, 0);
    chk("t5_async_rst_state", state_o, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    attempt(8'hB6, 8'h5A, 8'hC3);
    chk("t5_regrant", grant, 1);

    // 6a: ena=0 during GRANTED and ENTRY
    ena = 1'b0;
    tick(1);
    ena = 1'b1;
    chk("t6_ena_granted_state", state_o, 0);
    chk("t6_ena_granted_grant", grant, 0);
    attempt(8'h00, 8'h00, 8'h00);
    chk("t6_fail1", fail_count, 1);
    strobe(8'hB6);
    ena = 1'b0;
    tick(1);
    chk("t6_ena_entry_state", state_o, 0);
    chk("t6_ena_entry_fail", fail_count, 1);
    strobe(8'hB6);
    chk("t6_ena_strobe_ignored", state_o, 0);
    ena = 1'b1;

    // 6b: ena=0 for 10 cycles extends lockout by 10
    attempt(8'h00, 8'h00, 8'h00);
    attempt(8'h00, 8'h00, 8'h00);
    chk("t6_lockout_on", lockout, 1);
    tick(5);
    ena = 1'b0;
    tick(10);
    chk("t6_lockout_frozen", lockout, 1);
    ena = 1'b1;
    tick(11);
    chk("t6_lockout_26", lockout, 1);
    tick(1);
    chk("t6_lockout_27", lockout, 0);
    chk("t6_lockout_fail_clear", fail_count, 0);

    // 6c: reset mid-ENTRY
    attempt(8'h00, 8'h00, 8'h00);
    strobe(8'hB6);
    chk("t6_mid_entry", state_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", state_o, 0);
    chk("t6_rst_fail", fail_count, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_lockout", lockout, 0);
    chk("t6_rst_tampered", tampered, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    strobe(8'h5A);
    chk("t6_after_rst_idx", state_o, 1);
    strobe(8'hC3);
    strobe(8'hB6);
    chk("t6_after_rst_fail", fail_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
